// File: rtl/hazard_control.sv
// hazard_control: RAW hazard detection, operand forwarding selects and
// load-use / RAW stall sequencing for a 5-stage pipeline.
// Build option: define HAZARD_FORWARD_EN to enable forwarding (z4/z5 bypass
// plus a one-cycle load-use stall). Without it, every RAW dependency is
// resolved by stalling until the producer has left the pipeline.
//
// state    | meaning
// ---------+------------------------------------------------------------
// RUN      | normal flow, no stall; branches flush in the same cycle
// LU_STALL | one-cycle load-use bubble (forwarding build only)
// RAW_WAIT | counted stall until producer retires (non-forwarding build)

module hazard_control (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] ir3_output,
  input  logic [31:0] ir4_output,
  input  logic        branch_control_input,
  output logic [1:0]  select_operand1,
  output logic [1:0]  select_operand2,
  output logic [1:0]  select_md4,
  output logic [1:0]  select_ir4,
  output logic        stall,
  output logic        flush
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    RAW_WAIT = 2'd2
  } state_t;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  function automatic logic writes_rd(input logic [31:0] ir);
    logic w;
    case (ir[6:0])
      7'b0110011, 7'b0010011, 7'b0000011, 7'b0110111,
      7'b0010111, 7'b1101111, 7'b1100111: w = 1'b1;
      default:                            w = 1'b0;
    endcase
    return w && (ir[11:7] != 5'd0);
  endfunction

  function automatic logic reads_rs1(input logic [31:0] ir);
    logic r;
    case (ir[6:0])
      7'b0110011, 7'b0010011, 7'b0000011,
      7'b0100011, 7'b1100011, 7'b1100111: r = 1'b1;
      default:                            r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic reads_rs2(input logic [31:0] ir);
    logic r;
    case (ir[6:0])
      7'b0110011, 7'b0100011, 7'b1100011: r = 1'b1;
      default:                            r = 1'b0;
    endcase
    return r;
  endfunction

  state_t      state_q, state_d;
  logic [31:0] ir5_q, ir5_d;
  // Held low through reset and until the first edge after release, so no
  // output can follow the instruction inputs before the block is running.
  logic        live_q, live_d;

  logic m4_rs1, m4_rs2, m5_rs1, m5_rs2;
  logic hold;

  // Source/destination match of the execute instruction against ir4 and ir5.
  always_comb begin
    m4_rs1 = writes_rd(ir4_output) && reads_rs1(ir3_output) &&
             (ir3_output[19:15] == ir4_output[11:7]);
    m4_rs2 = writes_rd(ir4_output) && reads_rs2(ir3_output) &&
             (ir3_output[24:20] == ir4_output[11:7]);
    m5_rs1 = writes_rd(ir5_q) && reads_rs1(ir3_output) &&
             (ir3_output[19:15] == ir5_q[11:7]);
    m5_rs2 = writes_rd(ir5_q) && reads_rs2(ir3_output) &&
             (ir3_output[24:20] == ir5_q[11:7]);
  end

`ifdef HAZARD_FORWARD_EN
  logic       load4;
  logic [1:0] fwd1, fwd2;

  // A load result is not available at z4, so ir4 loads are not bypassed.
  always_comb begin
    load4 = (ir4_output[6:0] == OP_LOAD);
    fwd1  = (m4_rs1 && !load4) ? 2'd2 : (m5_rs1 ? 2'd1 : 2'd0);
    fwd2  = (m4_rs2 && !load4) ? 2'd2 : (m5_rs2 ? 2'd1 : 2'd0);
  end

  // Next state and outputs: a dependent load in ir4 costs one bubble.
  always_comb begin
    state_d         = state_q;
    hold            = 1'b0;
    select_operand1 = 2'd0;
    select_operand2 = 2'd0;
    select_md4      = 2'd0;
    select_ir4      = 2'd0;
    stall           = 1'b0;
    flush           = 1'b0;
    case (state_q)
      RUN:      if (load4 && (m4_rs1 || m4_rs2)) state_d = LU_STALL;
      LU_STALL: state_d = RUN;
      default:  state_d = RUN;
    endcase
    if (live_q) begin
      hold            = (state_q != RUN);
      stall           = hold;
      select_ir4      = hold ? 2'd1 : 2'd0;
      flush           = branch_control_input && !hold;
      select_operand1 = fwd1;
      select_operand2 = fwd2;
      select_md4      = (ir3_output[6:0] == OP_STORE) ? fwd2 : 2'd0;
    end
  end
`else
  logic [1:0] wait_cnt_q, wait_cnt_d;

  // Next state and outputs: stall 2 cycles for an ir4 producer, 1 for ir5.
  always_comb begin
    state_d         = state_q;
    wait_cnt_d      = wait_cnt_q;
    hold            = 1'b0;
    select_operand1 = 2'd0;
    select_operand2 = 2'd0;
    select_md4      = 2'd0;
    select_ir4      = 2'd0;
    stall           = 1'b0;
    flush           = 1'b0;
    case (state_q)
      RUN: begin
        if (m4_rs1 || m4_rs2) begin
          state_d    = RAW_WAIT;
          wait_cnt_d = 2'd2;
        end else if (m5_rs1 || m5_rs2) begin
          state_d    = RAW_WAIT;
          wait_cnt_d = 2'd1;
        end
      end
      RAW_WAIT: begin
        if (wait_cnt_q <= 2'd1) begin
          state_d    = RUN;
          wait_cnt_d = 2'd0;
        end else begin
          wait_cnt_d = wait_cnt_q - 2'd1;
        end
      end
      default: begin
        state_d    = RUN;
        wait_cnt_d = 2'd0;
      end
    endcase
    if (live_q) begin
      hold       = (state_q != RUN);
      stall      = hold;
      select_ir4 = hold ? 2'd1 : 2'd0;
      flush      = branch_control_input && !hold;
    end
  end

  // Wait counter register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) wait_cnt_q <= 2'd0;
    else        wait_cnt_q <= wait_cnt_d;
  end
`endif

  // Shadow of the instruction leaving the memory stage, and the live flag.
  always_comb begin
    ir5_d  = ir4_output;
    live_d = 1'b1;
  end

  // State, shadow and live-flag registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= RUN;
      ir5_q   <= 32'h0;
      live_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ir5_q   <= ir5_d;
      live_q  <= live_d;
    end
  end

  logic unused_bits;
  assign unused_bits = ^{ir3_output[31:25], ir3_output[14:7],
                         ir4_output[31:12], ir5_q[31:12]};

endmodule
